subleq_mem_arbiter: RTL

Shares the single SUBLEQ program/data RAM between two requesters: the SUBLEQ core (fetch of A/B/C operands, read of mem[A]/mem[B], write-back of mem[B]) and the program loader/debug port. Each access is latched, run as a fixed-length RAM cycle on the shared `ram_*` strobes and address/data bus, and acknowledged to the owning requester with a one-cycle ack. The block sits between the control unit/loader and the RAM; the core's address and data register muxes connect to the core-side port.

---
 rtl/subleq_pkg.sv | 23 ++
 rtl/subleq_mem_arbiter_if.sv | 51 +++++
 rtl/subleq_mem_arbiter_rr_arb2.sv | 31 +++
 rtl/subleq_mem_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ memory subsystem.
// Used by the RAM arbiter, its round-robin arbiter and the bus interface.
package subleq_pkg;

   localparam int DEF_ADR_W = 8;
   localparam int DEF_DAT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_LDR  = 1'b1
   } req_id_t;

   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;

endpackage

// File: rtl/subleq_mem_arbiter_if.sv
// Requester ports (core, loader) and the shared RAM strobes/bus.
// The arbiter takes the slave modport; the requesters and the RAM sit on the master side.
interface subleq_mem_arbiter_if #(
   parameter int ADR_W = subleq_pkg::DEF_ADR_W,
   parameter int DAT_W = subleq_pkg::DEF_DAT_W
);

   // Handshake: a requester raises req with we/adr/wdat stable and holds them until
   // its one-cycle ack; rdat is valid with the ack of a read and held until the next
   // read of that port completes. Req still high in the cycle after ack is a new request.
   logic             core_req;
   logic             core_we;
   logic [ADR_W-1:0] core_adr;
   logic [DAT_W-1:0] core_wdat;
   logic             core_ack;
   logic [DAT_W-1:0] core_rdat;

   logic             ldr_req;
   logic             ldr_we;
   logic [ADR_W-1:0] ldr_adr;
   logic [DAT_W-1:0] ldr_wdat;
   logic             ldr_ack;
   logic [DAT_W-1:0] ldr_rdat;

   logic [ADR_W-1:0] ram_adr;
   logic [DAT_W-1:0] ram_wdat;
   logic             ram_dat_oe;
   logic [DAT_W-1:0] ram_rdat;
   logic             ram_ena;
   logic             ram_ctl;
   logic             ram_ope;

   modport slave (
      input  core_req, core_we, core_adr, core_wdat,
      output core_ack, core_rdat,
      input  ldr_req, ldr_we, ldr_adr, ldr_wdat,
      output ldr_ack, ldr_rdat,
      output ram_adr, ram_wdat, ram_dat_oe, ram_ena, ram_ctl, ram_ope,
      input  ram_rdat
   );

   modport master (
      output core_req, core_we, core_adr, core_wdat,
      input  core_ack, core_rdat,
      output ldr_req, ldr_we, ldr_adr, ldr_wdat,
      input  ldr_ack, ldr_rdat,
      input  ram_adr, ram_wdat, ram_dat_oe, ram_ena, ram_ctl, ram_ope,
      output ram_rdat
   );

endinterface

// File: rtl/subleq_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, ties go to the port not granted last.
// last_grant only moves when the owning access completes (update strobe).
module rr_arb2
   import subleq_pkg::*;
(
   input  logic       clk,
   input  logic       res,
   input  logic [1:0] req,     // bit 0 = core, bit 1 = loader
   input  logic       update,
   input  req_id_t    owner,
   output logic [1:0] grant
);

   req_id_t last_grant;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         last_grant <= REQ_LDR;
      end else if (update) begin
         last_grant <= owner;
      end
   end

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = (last_grant == REQ_LDR) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/subleq_mem_arbiter.sv
// Shares the SUBLEQ RAM between core and loader: latch a granted command, run a
// fixed-length SETUP/ACCESS/DONE RAM cycle and pulse the owner's ack.
module subleq_mem_arbiter
   import subleq_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int          ADR_W       = DEF_ADR_W,
   parameter int          DAT_W       = DEF_DAT_W
) (
   input  logic                 clk,
   input  logic                 res,
   subleq_mem_arbiter_if.slave  bus,
   output logic                 busy,
   output state_t               state_dbg
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t           state;
   req_id_t          owner;
   logic [3:0]       wait_cnt;
   logic [1:0]       grant;
   logic [ADR_W-1:0] adr_q;
   logic [DAT_W-1:0] wdat_q;
   logic [DAT_W-1:0] core_rdat_q;
   logic [DAT_W-1:0] ldr_rdat_q;
   logic             ena_q, ope_q, oe_q, ctl_q;

   logic             sel_we;
   logic [ADR_W-1:0] sel_adr;
   logic [DAT_W-1:0] sel_wdat;

   rr_arb2 u_arb (
      .clk    (clk),
      .res    (res),
      .req    ({bus.ldr_req, bus.core_req}),
      .update (state == DONE),
      .owner  (owner),
      .grant  (grant)
   );

   always_comb begin
      sel_we   = grant[1] ? bus.ldr_we   : bus.core_we;
      sel_adr  = grant[1] ? bus.ldr_adr  : bus.core_adr;
      sel_wdat = grant[1] ? bus.ldr_wdat : bus.core_wdat;
   end

   // ram_ctl doubles as the latched we bit; it stays put from SETUP through DONE.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state       <= IDLE;
         owner       <= REQ_CORE;
         wait_cnt    <= '0;
         adr_q       <= '0;
         wdat_q      <= '0;
         core_rdat_q <= '0;
         ldr_rdat_q  <= '0;
         ena_q       <= 1'b0;
         ope_q       <= 1'b0;
         oe_q        <= 1'b0;
         ctl_q       <= RAM_READ;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  owner  <= grant[1] ? REQ_LDR : REQ_CORE;
                  adr_q  <= sel_adr;
                  wdat_q <= sel_wdat;
                  ctl_q  <= sel_we;
                  oe_q   <= sel_we;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               ena_q    <= 1'b1;
               ope_q    <= (ctl_q == RAM_READ);
               wait_cnt <= WAIT_INIT;
               state    <= ACCESS;
            end
            ACCESS: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  if (ctl_q == RAM_READ) begin
                     if (owner == REQ_LDR) ldr_rdat_q  <= bus.ram_rdat;
                     else                  core_rdat_q <= bus.ram_rdat;
                  end
                  ena_q <= 1'b0;
                  ope_q <= 1'b0;
                  oe_q  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ram_adr    = adr_q;
   assign bus.ram_wdat   = wdat_q;
   assign bus.ram_ena    = ena_q;
   assign bus.ram_ope    = ope_q;
   assign bus.ram_dat_oe = oe_q;
   assign bus.ram_ctl    = ctl_q;
   assign bus.core_rdat  = core_rdat_q;
   assign bus.ldr_rdat   = ldr_rdat_q;
   assign bus.core_ack   = (state == DONE) && (owner == REQ_CORE);
   assign bus.ldr_ack    = (state == DONE) && (owner == REQ_LDR);
   assign busy           = (state != IDLE);
   assign state_dbg      = state;

endmodule
